// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - multi-cycle RV32I control FSM
// Sequences fetch/decode/exec/mem/wb and owns every datapath enable.
module rv_multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [2:0] sext_sel,
  output logic       alu_src_b,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [3:0] C_R      = 4'd0;
  localparam logic [3:0] C_OPIMM  = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_JALR   = 4'd3;
  localparam logic [3:0] C_STORE  = 4'd4;
  localparam logic [3:0] C_BRANCH = 4'd5;
  localparam logic [3:0] C_LUI    = 4'd6;
  localparam logic [3:0] C_AUIPC  = 4'd7;
  localparam logic [3:0] C_JAL    = 4'd8;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_next;
  logic [1:0] cause_q, cause_next;
  logic [3:0] cls_q, dec_cls;
  logic [2:0] sext_q, dec_sext;
  logic       dec_legal;
  logic [7:0] cnt;

  // funct3 is carried for future extension only
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  always_comb begin
    dec_cls   = C_R;
    dec_sext  = 3'd5;
    dec_legal = 1'b1;
    case (opcode)
      7'd51:   begin dec_cls = C_R;      dec_sext = 3'd5; end
      7'd19:   begin dec_cls = C_OPIMM;  dec_sext = 3'd0; end
      7'd3:    begin dec_cls = C_LOAD;   dec_sext = 3'd0; end
      7'd103:  begin dec_cls = C_JALR;   dec_sext = 3'd0; end
      7'd35:   begin dec_cls = C_STORE;  dec_sext = 3'd3; end
      7'd99:   begin dec_cls = C_BRANCH; dec_sext = 3'd1; end
      7'd55:   begin dec_cls = C_LUI;    dec_sext = 3'd2; end
      7'd23:   begin dec_cls = C_AUIPC;  dec_sext = 3'd2; end
      7'd111:  begin dec_cls = C_JAL;    dec_sext = 3'd4; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      cause_q <= 2'd0;
      cls_q   <= C_R;
      sext_q  <= 3'd0;
      cnt     <= 8'd0;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state == S_DECODE) begin
        cls_q  <= dec_cls;
        sext_q <= dec_sext;
      end
      // any state change clears the wait counter, so FETCH/MEM always start at 0
      if (state_next != state)
        cnt <= 8'd0;
      else if (state == S_FETCH || state == S_MEM)
        cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    case (state)
      S_FETCH: begin
        if (imem_ack)            state_next = S_DECODE;
        else if (cnt == TO_LAST) begin state_next = S_TRAP; cause_next = 2'd2; end
      end
      S_DECODE: begin
        if (dec_legal) state_next = S_EXEC;
        else begin state_next = S_TRAP; cause_next = 2'd1; end
      end
      S_EXEC: begin
        if (cls_q == C_BRANCH)                         state_next = S_FETCH;
        else if (cls_q == C_LOAD || cls_q == C_STORE)  state_next = S_MEM;
        else                                           state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)            state_next = (cls_q == C_STORE) ? S_FETCH : S_WB;
        else if (cnt == TO_LAST) begin state_next = S_TRAP; cause_next = 2'd3; end
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: begin state_next = S_TRAP; cause_next = 2'd1; end
    endcase
  end

  // outputs are gated by rst_n so requests drop the moment reset asserts
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXEC: begin
          alu_src_b = (cls_q != C_R) && (cls_q != C_BRANCH);
          if (cls_q == C_BRANCH) begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? 2'd1 : 2'd0;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
          pc_we    = (cls_q == C_STORE) && dmem_ack;
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          if (cls_q == C_LOAD)                         wb_sel = 2'd1;
          else if (cls_q == C_JAL || cls_q == C_JALR)  wb_sel = 2'd2;
          if (cls_q == C_JAL)       pc_src = 2'd1;
          else if (cls_q == C_JALR) pc_src = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign sext_sel   = sext_q;
  assign trap_cause = cause_q;
  assign trap       = rst_n && (state == S_TRAP);

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback.
- Drives the immediate sign-extension select, ALU/PC/writeback muxes and register-file write enable.
- Handshakes with instruction and data memory using req/ack.
- Sits between the instruction register and the datapath. Owns all datapath enables.

Parameters:
- TIMEOUT, default 16: maximum cycles a memory request may wait for ack before a bus-error trap. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12] from the instruction register
- branch_taken  input  1  ALU compare result, valid in EXEC
- imem_ack  input  1  instruction memory has returned data
- dmem_ack  input  1  data memory access complete
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data access request
- dmem_we  output  1  1 = store, 0 = load
- ir_we  output  1  load the instruction register
- pc_we  output  1  update the PC
- pc_src  output  2  PC source: 0 = pc+4, 1 = pc+imm, 2 = ALU result
- sext_sel  output  3  immediate type: 0 = I, 1 = B, 2 = U, 3 = S, 4 = J, 5 = none
- alu_src_b  output  1  ALU B operand: 0 = rs2, 1 = immediate
- reg_we  output  1  register-file write enable
- wb_sel  output  2  writeback source: 0 = ALU, 1 = memory, 2 = pc+4
- trap  output  1  sticky fault flag
- trap_cause  output  2  fault cause: 0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout
- state  output  3  current FSM state, for debug

Behaviour:
- Reset: asynchronous and active-low. While rst_n = 0:
  - state = FETCH
  - every output = 0, including sext_sel = 0 and trap_cause = 0
  - timeout counter = 0
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. Any other encoding transitions to TRAP with cause 1.
- Opcode classes (decimal):
  - 51 R: sext_sel 5
  - 19 OP-IMM: sext_sel 0
  - 3 LOAD: sext_sel 0
  - 103 JALR: sext_sel 0
  - 35 STORE: sext_sel 3
  - 99 BRANCH: sext_sel 1
  - 55 LUI: sext_sel 2
  - 23 AUIPC: sext_sel 2
  - 111 JAL: sext_sel 4
  - Any other opcode is illegal.
- FETCH:
  - imem_req = 1 and held until imem_ack.
  - On the ack cycle: ir_we = 1 for one cycle, then go to DECODE.
- DECODE (1 cycle):
  - Register sext_sel and the opcode class; both are held until the next DECODE.
  - Illegal opcode: go to TRAP with cause 1.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - alu_src_b = 1 for every class except R and BRANCH.
  - BRANCH: pc_we = 1; pc_src = 1 if branch_taken, else 0. Next state FETCH.
  - LOAD/STORE: next state MEM.
  - All other classes: next state WB.
- MEM:
  - dmem_req = 1 and held until dmem_ack. dmem_we = 1 for STORE only.
  - STORE ack: pc_we = 1, pc_src = 0, go to FETCH.
  - LOAD ack: go to WB.
- WB (1 cycle):
  - reg_we = 1 and pc_we = 1.
  - wb_sel: 1 for LOAD; 2 for JAL and JALR; 0 otherwise.
  - pc_src: 1 for JAL; 2 for JALR; 0 otherwise.
  - Next state FETCH.
- Timeout counter:
  - Cleared on entry to FETCH or MEM; increments each waiting cycle.
  - If TIMEOUT cycles pass without ack: go to TRAP with cause 2 in FETCH or 3 in MEM.
  - An ack arriving in the same cycle the count reaches TIMEOUT wins; no trap is taken.
- TRAP:
  - All requests and enables = 0; trap = 1; trap_cause held.
  - Exit only by reset.
- Acks outside the matching wait state are ignored.
- funct3 affects no control output. It is routed for future extension.
- All enables are Moore outputs of the registered state, with one exception: the ack-cycle pulses (ir_we, MEM pc_we) are combinational from the ack.
- Reset asserted mid-transaction: all requests drop in the same cycle; the FSM restarts in FETCH.

Test Plan:
- ADDI (opcode 19), imem_ack on 1st cycle -> states 0,1,2,4,0; sext_sel = 0; alu_src_b = 1; reg_we = 1 for one cycle; wb_sel = 0; pc_src = 0.
- BEQ (99) with branch_taken = 1 -> sext_sel = 1; pc_we = 1 and pc_src = 1 in EXEC; reg_we never asserted; back to FETCH after 3 cycles.
- SW (35), dmem_ack after 3 cycles -> sext_sel = 3; dmem_req and dmem_we held 3 cycles; pc_we pulses on the ack cycle; reg_we stays 0.
- LW (3) then JAL (111) back to back -> LW: wb_sel = 1 in WB. JAL: sext_sel = 4, wb_sel = 2, pc_src = 1.
- Opcode 0x7F -> TRAP after DECODE; trap = 1, trap_cause = 1; imem_req stays 0 thereafter. Deassert then reassert rst_n -> FETCH with trap = 0.
- TIMEOUT = 4, imem_ack never asserted -> trap_cause = 2 after 4 waiting cycles. Repeat with ack on the 4th cycle -> no trap.
